// File: rtl/dtw_sdtw_stream_array_if.sv
// Stream/control bundle for the subsequence-DTW systolic engine.
// master = feeder/controller side, slave = the engine.
interface dtw_sdtw_stream_array_if #(
  parameter int W   = 16,
  parameter int NPE = 256,
  parameter int PW  = 32
);
  localparam int QW = $clog2(NPE + 1);

  // Every stream transfers exactly one sample on a clock edge where valid && ready.
  // Valid may be raised or dropped freely; ready comes from the engine state only.
  logic          start;
  logic [QW-1:0] qlen;
  logic [PW-1:0] ref_len;
  logic          q_valid;
  logic [W-1:0]  q_data;
  logic          q_ready;
  logic          r_valid;
  logic [W-1:0]  r_data;
  logic          r_ready;
  logic          busy;
  logic          done;
  logic [W-1:0]  min_cost;
  logic [PW-1:0] min_pos;
  logic [2:0]    dbg_state;

  modport master (
    output start, qlen, ref_len, q_valid, q_data, r_valid, r_data,
    input  q_ready, r_ready, busy, done, min_cost, min_pos, dbg_state
  );
  modport slave (
    input  start, qlen, ref_len, q_valid, q_data, r_valid, r_data,
    output q_ready, r_ready, busy, done, min_cost, min_pos, dbg_state
  );
endinterface

// File: rtl/dtw_sdtw_stream_array.sv
// Subsequence-DTW systolic engine: query held one sample per PE, reference streamed through.
// Optional macro DTW_SQDIST_EN selects squared distance with one extra register stage per PE.
module dtw_sdtw_stream_array #(
  parameter int W   = 16,
  parameter int NPE = 256,
  parameter int PW  = 32
) (
  input logic clk,
  input logic rst,
  dtw_sdtw_stream_array_if.slave bus
);
  localparam int QW = $clog2(NPE + 1);
  localparam int IW = (NPE > 1) ? $clog2(NPE) : 1;
  localparam logic [W-1:0]  ONES  = '1;
  localparam logic [QW-1:0] Q_ONE = QW'(1);
  localparam logic [QW-1:0] Q_NPE = QW'(NPE);
`ifdef DTW_SQDIST_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state;

  logic [QW-1:0] qlen_r, lcnt, dcnt, qeff, qeff_m1, drain_len;
  logic [PW-1:0] rlen_r, rcnt;
  logic [IW-1:0] last_idx;

  logic [W-1:0]  q_q [NPE];
  logic [W-1:0]  r_q [NPE];
  logic [W-1:0]  c_q [NPE];
  logic [W-1:0]  d_q [NPE];
  logic [PW-1:0] j_q [NPE];
  logic          v_q [NPE];
  logic [W-1:0]  r_in [NPE];
  logic [PW-1:0] j_in [NPE];
  logic          v_in [NPE];
  logic [W-1:0]  up [NPE];
  logic [W-1:0]  dist_now [NPE];
  logic [W-1:0]  cd [NPE];
  logic [PW-1:0] cj [NPE];
  logic          cv [NPE];
  logic [W-1:0]  nc [NPE];
`ifdef DTW_SQDIST_EN
  logic [W-1:0]  dist_q [NPE];
`endif

  function automatic logic [W-1:0] pe_dist(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]   d;
    logic [2*W-1:0] sq;
    d  = (a >= b) ? a - b : b - a;
    sq = {{W{1'b0}}, d} * {{W{1'b0}}, d};
`ifdef DTW_SQDIST_EN
    pe_dist = (|sq[2*W-1:W]) ? ONES : sq[W-1:0];
`else
    pe_dist = (sq[0] == d[0]) ? d : d;
`endif
  endfunction

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = s[W] ? ONES : s[W-1:0];
  endfunction

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    min3 = (m < c) ? m : c;
  endfunction

  logic adv, clr;
  assign adv = ((state == S_RUN) && bus.r_valid) || (state == S_DRAIN);
  assign clr = (state == S_IDLE) && bus.start;

  assign qeff      = ((bus.qlen == '0) || (bus.qlen > Q_NPE)) ? Q_NPE : bus.qlen;
  assign qeff_m1   = qeff - Q_ONE;
  assign drain_len = qlen_r - Q_ONE + QW'(XTRA);

  // PE i sees column j one step after PE i-1; its diagonal is the "up" it used last step.
  for (genvar i = 0; i < NPE; i++) begin : g_pe
    if (i == 0) begin : g_first
      assign r_in[i] = bus.r_data;
      assign j_in[i] = rcnt;
      assign v_in[i] = (state == S_RUN);
      assign up[i]   = '0;
    end else begin : g_rest
      assign r_in[i] = r_q[i-1];
      assign j_in[i] = j_q[i-1];
      assign v_in[i] = v_q[i-1];
      assign up[i]   = c_q[i-1];
    end
    assign dist_now[i] = pe_dist(q_q[i], r_in[i]);
`ifdef DTW_SQDIST_EN
    assign cv[i] = v_q[i];
    assign cd[i] = dist_q[i];
    assign cj[i] = j_q[i];
`else
    assign cv[i] = v_in[i];
    assign cd[i] = dist_now[i];
    assign cj[i] = j_in[i];
`endif
    assign nc[i] = sat_add(cd[i], min3(up[i], c_q[i], d_q[i]));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < NPE; i++) begin
        c_q[i] <= ONES;
        d_q[i] <= ONES;
        v_q[i] <= 1'b0;
        r_q[i] <= '0;
        j_q[i] <= '0;
`ifdef DTW_SQDIST_EN
        dist_q[i] <= '0;
`endif
      end
    end else begin
      if (bus.q_valid && bus.q_ready) q_q[lcnt[IW-1:0]] <= bus.q_data;
      if (adv) begin
        for (int i = 0; i < NPE; i++) begin
          if (cv[i]) begin
            c_q[i] <= nc[i];
            d_q[i] <= up[i];
          end
          r_q[i] <= r_in[i];
          j_q[i] <= j_in[i];
          v_q[i] <= v_in[i];
`ifdef DTW_SQDIST_EN
          dist_q[i] <= dist_now[i];
`endif
        end
      end
    end
  end

  assign bus.dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      bus.q_ready  <= 1'b0;
      bus.r_ready  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.min_cost <= ONES;
      bus.min_pos  <= '0;
      qlen_r       <= Q_NPE;
      rlen_r       <= PW'(1);
      last_idx     <= '0;
      lcnt         <= '0;
      rcnt         <= '0;
      dcnt         <= '0;
    end else begin
      bus.done <= 1'b0;
      // The last-row cost is taken on the same edge that registers it in PE qlen-1.
      if (adv && cv[last_idx] && (nc[last_idx] < bus.min_cost)) begin
        bus.min_cost <= nc[last_idx];
        bus.min_pos  <= cj[last_idx];
      end
      case (state)
        S_IDLE: if (bus.start) begin
          qlen_r       <= qeff;
          rlen_r       <= (bus.ref_len == '0) ? PW'(1) : bus.ref_len;
          last_idx     <= qeff_m1[IW-1:0];
          lcnt         <= '0;
          rcnt         <= '0;
          dcnt         <= '0;
          bus.min_cost <= ONES;
          bus.min_pos  <= '0;
          bus.q_ready  <= 1'b1;
          bus.busy     <= 1'b1;
          state        <= S_LOAD;
        end
        S_LOAD: if (bus.q_valid) begin
          lcnt <= lcnt + Q_ONE;
          if (lcnt == qlen_r - Q_ONE) begin
            bus.q_ready <= 1'b0;
            bus.r_ready <= 1'b1;
            state       <= S_RUN;
          end
        end
        S_RUN: if (bus.r_valid) begin
          rcnt <= rcnt + PW'(1);
          if (rcnt == rlen_r - PW'(1)) begin
            bus.r_ready <= 1'b0;
            if (drain_len == '0) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= S_DONE;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          dcnt <= dcnt + Q_ONE;
          if (dcnt == drain_len - Q_ONE) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dtw_sdtw_stream_array.sv
// Bench for dtw_sdtw_stream_array: vector table, stall/reset/saturation sequences, random cases
// checked against a full-matrix reference model through an expected-result queue.
module tb_dtw_sdtw_stream_array;
  localparam int W    = 16;
  localparam int NPE  = 16;
  localparam int PW   = 32;
  localparam int MAXR = 40;
  localparam int QW   = $clog2(NPE + 1);
  localparam int ONES = (1 << W) - 1;
`ifdef DTW_SQDIST_EN
  localparam int XTRA = 1;
  localparam int EC_Q3R1 = 4;
  localparam int EC_RL0  = 25;
  localparam int EC_TIE1 = 4;
`else
  localparam int XTRA = 0;
  localparam int EC_Q3R1 = 2;
  localparam int EC_RL0  = 5;
  localparam int EC_TIE1 = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dtw_sdtw_stream_array_if #(.W(W), .NPE(NPE), .PW(PW)) bus ();
  dtw_sdtw_stream_array #(.W(W), .NPE(NPE), .PW(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [W+PW-1:0] exp_q[$];
  logic [W-1:0] cur_q [NPE];
  logic [W-1:0] cur_r [MAXR];

  typedef struct {
    int ql;
    int rl;
    logic [3:0][W-1:0] q;
    logic [7:0][W-1:0] r;
    int ec;
    int ep;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int ref_dist(input int a, input int b);
    longint d;
    d = (a > b) ? a - b : b - a;
`ifdef DTW_SQDIST_EN
    d = d * d;
`endif
    return (d > ONES) ? ONES : int'(d);
  endfunction

  task automatic model(input int ql, input int rl, output int c, output int p);
    int prev [NPE];
    int cur  [NPE];
    int up, dg, m, s;
    for (int i = 0; i < NPE; i++) begin
      prev[i] = ONES;
      cur[i]  = ONES;
    end
    c = ONES;
    p = 0;
    for (int j = 0; j < rl; j++) begin
      for (int i = 0; i < ql; i++) begin
        up = (i == 0) ? 0 : cur[i-1];
        dg = (i == 0) ? 0 : prev[i-1];
        m  = (up < prev[i]) ? up : prev[i];
        m  = (dg < m) ? dg : m;
        s  = ref_dist(int'(cur_q[i]), int'(cur_r[j])) + m;
        cur[i] = (s > ONES) ? ONES : s;
      end
      if (cur[ql-1] < c) begin
        c = cur[ql-1];
        p = j;
      end
      prev = cur;
    end
  endtask

  // Full transaction: start, load query, stream reference, wait for done, compare.
  task automatic run_case(input int ql, input int rl, input bit stall, input int ec, input int ep);
    int qe, re, k, guard, lat;
    bit acc;
    logic [W+PW-1:0] got;
    qe = (ql == 0 || ql > NPE) ? NPE : ql;
    re = (rl == 0) ? 1 : rl;
    exp_q.push_back({W'(ec), PW'(ep)});
    @(negedge clk);
    bus.qlen = QW'(ql); bus.ref_len = PW'(rl); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    k = 0; guard = 0;
    while (k < qe && guard < 1000) begin
      bus.q_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.q_data  = cur_q[k];
      acc = bus.q_valid && bus.q_ready;
      @(negedge clk);
      if (acc) k++;
      guard++;
    end
    bus.q_valid = 1'b0;
    check("query_loaded", k, qe);
    k = 0; guard = 0;
    while (k < re && guard < 2000) begin
      bus.r_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.r_data  = cur_r[k];
      if (stall) begin
        bus.start = 1'b1; bus.qlen = QW'(1); bus.ref_len = PW'(99);
      end
      acc = bus.r_valid && bus.r_ready;
      @(negedge clk);
      if (acc) k++;
      guard++;
    end
    bus.r_valid = 1'b0;
    bus.start   = 1'b0;
    check("ref_streamed", k, re);
    check("r_ready_drop", bus.r_ready, 0);
    lat = 1;
    while (!bus.done && lat < 4 * NPE + 8) begin
      @(negedge clk);
      lat++;
    end
    check("done_latency", lat, qe + XTRA);
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        got = exp_q.pop_front();
        check("min_cost", bus.min_cost, got[W+PW-1:PW]);
        check("min_pos", bus.min_pos, got[PW-1:0]);
      end
    end
    @(negedge clk);
    check("done_pulse", bus.done, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  task automatic load_tbl(input int n);
    for (int i = 0; i < 4; i++) cur_q[i] = tbl[n].q[i];
    for (int j = 0; j < 8; j++) cur_r[j] = tbl[n].r[j];
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_q_ready"}, bus.q_ready, 0);
    check({tag, "_r_ready"}, bus.r_ready, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_min_cost"}, bus.min_cost, ONES);
    check({tag, "_min_pos"}, bus.min_pos, 0);
    check({tag, "_state"}, bus.dbg_state, 0);
  endtask

  int ql, rl, qe, hi, ec, ep;

  initial begin
    bus.start = 1'b0; bus.qlen = '0; bus.ref_len = '0;
    bus.q_valid = 1'b0; bus.q_data = '0; bus.r_valid = 1'b0; bus.r_data = '0;

    tbl[0] = '{ql: 3, rl: 6, q: {16'd0, 16'd7, 16'd6, 16'd5},
               r: {16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd6, 16'd5, 16'd0}, ec: 0, ep: 3};
    tbl[1] = '{ql: 2, rl: 4, q: {16'd0, 16'd0, 16'd10, 16'd10},
               r: {16'd0, 16'd0, 16'd0, 16'd0, 16'd10, 16'd10, 16'd20, 16'd0}, ec: 0, ep: 2};
    tbl[2] = '{ql: 2, rl: 3, q: {16'd0, 16'd0, 16'd10, 16'd10},
               r: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd10, 16'd10, 16'd10}, ec: 0, ep: 0};
    tbl[3] = '{ql: 1, rl: 3, q: {16'd0, 16'd0, 16'd0, 16'd3},
               r: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd3, 16'd5, 16'd0}, ec: 0, ep: 2};
    tbl[4] = '{ql: 1, rl: 1, q: {16'd0, 16'd0, 16'd0, 16'd3},
               r: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1}, ec: EC_Q3R1, ep: 0};
    tbl[5] = '{ql: 2, rl: 0, q: {16'd0, 16'd0, 16'd9, 16'd4},
               r: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd4}, ec: EC_RL0, ep: 0};
    tbl[6] = '{ql: 2, rl: 4, q: {16'd0, 16'd0, 16'd2, 16'd1},
               r: {16'd0, 16'd0, 16'd0, 16'd0, 16'd4, 16'd1, 16'd6, 16'd5}, ec: 1, ep: 2};
    tbl[7] = '{ql: 1, rl: 4, q: {16'd0, 16'd0, 16'd0, 16'd5},
               r: {16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd9, 16'd3, 16'd7}, ec: EC_TIE1, ep: 0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    for (int n = 0; n < 8; n++) begin
      load_tbl(n);
      run_case(tbl[n].ql, tbl[n].rl, 1'b0, tbl[n].ec, tbl[n].ep);
    end

    // Random valid gaps plus start/qlen/ref_len noise while busy must not alter the result.
    load_tbl(0);
    run_case(3, 6, 1'b1, 0, 3);

    // Full-length query saturates on the first row and never wraps.
    for (int i = 0; i < NPE; i++) cur_q[i] = W'(ONES);
    for (int j = 0; j < 5; j++) cur_r[j] = '0;
    run_case(NPE, 5, 1'b0, ONES, 0);

    // Reset in the middle of RUN discards everything.
    load_tbl(0);
    @(negedge clk);
    bus.qlen = QW'(3); bus.ref_len = PW'(6); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.q_valid = 1'b1; bus.q_data = cur_q[k];
      @(negedge clk);
    end
    bus.q_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.r_valid = 1'b1; bus.r_data = cur_r[k];
      @(negedge clk);
    end
    bus.r_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");
    rst = 1'b0;
    run_case(3, 6, 1'b0, 0, 3);

    for (int t = 0; t < 6; t++) begin
      ql = (t == 0) ? 0 : $urandom_range(1, NPE);
      rl = $urandom_range(1, MAXR);
      qe = (ql == 0) ? NPE : ql;
      hi = (t == 5) ? ONES : 15;
      for (int i = 0; i < NPE; i++) cur_q[i] = W'($urandom_range(0, hi));
      for (int j = 0; j < MAXR; j++) cur_r[j] = W'($urandom_range(0, hi));
      model(qe, rl, ec, ep);
      run_case(ql, rl, t[0], ec, ep);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
